// File: rtl/market_feed_parser.sv
// market_feed_parser
//
// Parses fixed 11-byte price frames from the Ethernet receive byte stream:
//   b0 = MAGIC, b1 = symbol, b2..b9 = price (MSB first), b10 = XOR of b1..b9.
// rx_last must mark b10 and no other byte. Accepted BTC/ETH prices are held
// in 64-bit registers with a one-cycle update strobe. Malformed frames are
// counted once each and never touch the held prices.
//
// Handshake: rx_valid qualifies rx_data/rx_last in the same cycle. There is
// no ready; every cycle with rx_valid=1 consumes exactly one byte, and
// cycles with rx_valid=0 leave all state untouched.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   rx_data    in   [7:0] stream byte
//   rx_valid   in   rx_data valid this cycle
//   rx_last    in   final byte of a frame (only meaningful with rx_valid)
//   btc_price  out  [63:0] last accepted BTC price
//   eth_price  out  [63:0] last accepted ETH price
//   btc_upd    out  one-cycle pulse when btc_price is written
//   eth_upd    out  one-cycle pulse when eth_price is written
//   pkt_count  out  [CNT_W-1:0] accepted frames, wraps
//   err_count  out  [CNT_W-1:0] rejected frames, saturates
//   fsm_state  out  [2:0] current parser state, for observation

module market_feed_parser #(
    parameter logic [7:0] MAGIC  = 8'hA5,
    parameter logic [7:0] BTC_ID = 8'h01,
    parameter logic [7:0] ETH_ID = 8'h02,
    parameter int         CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             rx_last,
    output logic [63:0]      btc_price,
    output logic [63:0]      eth_price,
    output logic             btc_upd,
    output logic             eth_upd,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count,
    output logic [2:0]       fsm_state
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SYM   = 3'd1;
    localparam logic [2:0] PRICE = 3'd2;
    localparam logic [2:0] CSUM  = 3'd3;
    localparam logic [2:0] DROP  = 3'd4;

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [7:0]  sym;
    logic [7:0]  acc;
    logic [63:0] shift;
    logic [2:0]  idx;
    logic        take_err;
    logic        accept;
    logic        csum_ok;

    assign fsm_state = state;

    always_comb begin
        next_state = state;
        take_err   = 1'b0;
        accept     = 1'b0;
        csum_ok    = rx_last && (rx_data == acc) &&
                     ((sym == BTC_ID) || (sym == ETH_ID));
        if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_data == MAGIC) begin
                        if (rx_last) take_err = 1'b1;
                        else         next_state = SYM;
                    end else begin
                        // A stray non-magic byte is charged as one bad frame;
                        // DROP then swallows the rest of it silently.
                        take_err = 1'b1;
                        if (!rx_last) next_state = DROP;
                    end
                end
                SYM: begin
                    if (rx_last) begin
                        take_err   = 1'b1;
                        next_state = IDLE;
                    end else begin
                        next_state = PRICE;
                    end
                end
                PRICE: begin
                    if (rx_last) begin
                        take_err   = 1'b1;
                        next_state = IDLE;
                    end else if (idx == 3'd7) begin
                        next_state = CSUM;
                    end
                end
                CSUM: begin
                    if (csum_ok) accept   = 1'b1;
                    else         take_err = 1'b1;
                    // Without rx_last the frame is overlong; the error is
                    // already taken here, so DROP only resynchronises.
                    next_state = rx_last ? IDLE : DROP;
                end
                DROP: begin
                    if (rx_last) next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sym       <= 8'h00;
            acc       <= 8'h00;
            shift     <= 64'h0;
            idx       <= 3'd0;
            btc_price <= 64'h0;
            eth_price <= 64'h0;
            btc_upd   <= 1'b0;
            eth_upd   <= 1'b0;
            pkt_count <= '0;
            err_count <= '0;
        end else begin
            btc_upd <= 1'b0;
            eth_upd <= 1'b0;
            state   <= next_state;
            if (rx_valid) begin
                case (state)
                    SYM: begin
                        sym <= rx_data;
                        acc <= rx_data;
                        idx <= 3'd0;
                    end
                    PRICE: begin
                        shift <= {shift[55:0], rx_data};
                        acc   <= acc ^ rx_data;
                        idx   <= idx + 3'd1;
                    end
                    default: ;
                endcase
            end
            // The shift register already holds all eight price bytes when
            // the checksum byte is sampled, so commit straight from it.
            if (accept) begin
                pkt_count <= pkt_count + 1'b1;
                if (sym == BTC_ID) begin
                    btc_price <= shift;
                    btc_upd   <= 1'b1;
                end else begin
                    eth_price <= shift;
                    eth_upd   <= 1'b1;
                end
            end
            if (take_err && (err_count != {CNT_W{1'b1}})) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule
